mul_issue_queue: RTL and testbench
==================================

// Module: mul_issue_queue
// PURPOSE
//  Reservation station for multiply instructions; sits between rename/dispatch and the MUL pipeline.
//  Holds up to DEPTH renamed mul ops and captures operand-ready wakeups from the CDB broadcast ports.
//  Each cycle it issues at most one op, the oldest ready one, through a registered issue port.
//  iss_src_a/iss_src_b drive the PRF read ports; iss_valid/iss_prf_dst/iss_rob_tag drive the MUL unit's valid/tag inputs.
// PARAMETERS
//  DEPTH   4  number of queue entries (2..8)
//  PRF_W   5  physical register tag width
//  ROB_W   4  ROB tag width
//  NCDB    2  number of wakeup broadcast ports (ALU, MUL)
// PORTS
//  clk          in   1            clock
//  rst          in   1            async reset, active-low
//  flush        in   1            sync clear of all entries and issue regs (mispredict)
//  freeze_back  in   1            back-end stall: hold issue regs, no select
//  disp_valid   in   1            dispatch request
//  disp_src_a   in   PRF_W        source A phys tag
//  disp_rdy_a   in   1            source A ready at rename
//  disp_src_b   in   PRF_W        source B phys tag
//  disp_rdy_b   in   1            source B ready at rename
//  disp_dst     in   PRF_W        destination phys tag
//  disp_rob     in   ROB_W        ROB tag
//  full         out  1            count==DEPTH (combinational from state)
//  wb_valid     in   NCDB         per-port broadcast valid
//  wb_tag       in   NCDB*PRF_W   per-port broadcast tag, port i at [i*PRF_W +: PRF_W]
//  iss_valid    out  1            issued op valid (registered)
//  iss_src_a    out  PRF_W        to PRF read port A
//  iss_src_b    out  PRF_W        to PRF read port B
//  iss_prf_dst  out  PRF_W        destination phys tag
//  iss_rob_tag  out  ROB_W        ROB tag
// BEHAVIOUR
//  Reset: all entry valid bits 0, count 0, full 0; all iss_* outputs 0.
//  Storage: collapsing queue; entry 0 is oldest. Fields: v, src_a, rdy_a, src_b, rdy_b, dst, rob.
//  Wakeup: for each valid entry, rdy_x <= 1 if any wb_valid[i] && wb_tag[i]==src_x. Same-cycle
//   dispatch also matches: the written rdy_x = disp_rdy_x | match on disp_src_x.
//  Select: lowest-index entry with v && rdy_a && rdy_b, using pre-edge rdy values;
//   an op woken this cycle is selectable next cycle (1-cycle wakeup->issue minimum).
//  Issue (freeze_back=0): on edge, iss_* <= selected entry, iss_valid <= 1; the entry is removed and
//   entries above it shift down one. No ready entry -> iss_valid <= 0, other iss_* hold.
//  freeze_back=1: iss_* all hold; no select, no removal; wakeup and dispatch continue.
//  Dispatch: accepted iff disp_valid && !full && !flush; written at index count (after any shift,
//   i.e. index count-1 when an issue also happens in the same cycle). Rejected when full even if
//   an issue frees a slot the same cycle; the dispatcher must hold and retry.
//  count: +1 on dispatch, -1 on issue, unchanged if both; never exceeds DEPTH or underflows.
//  flush: next edge all v=0, count=0, iss_valid=0; overrides dispatch, issue and freeze_back.
//  Reset asserted mid-operation: immediate clear to reset values; in-flight ops are lost.
//  Issue latency: dispatch with both sources ready -> iss_valid high on the following edge (1 cycle).
// TESTING
//  1. Dispatch dst=7,rob=3,src rdy -> next cycle iss_valid=1, iss_prf_dst=7, iss_rob_tag=3; count back to 0.
//  2. Dispatch src_a=9 not ready; wb_valid=01, wb_tag[0]=9 two cycles later -> issue exactly 1 cycle after the wakeup.
//  3. Wakeup on tag 12 in same cycle as dispatch with src_b=12,rdy_b=0 -> entry captured ready, issues next cycle.
//  4. Fill 4 non-ready ops: full=1; 5th dispatch dropped; wake entry 2 only -> it issues, entries 3->2, full=0.
//  5. Two ready ops (rob 1, rob 2), freeze_back=1 for 3 cycles -> iss_* frozen on rob 1's issue; rob 2 issues 1 cycle after release.
//  6. Queue with 3 entries, flush=1 with disp_valid=1 -> next cycle count=0, iss_valid=0, full=0, nothing issues later.

Source files
------------

// File: rtl/mul_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : mul_issue_queue
//  Purpose  : Reservation station for multiply ops. It sits between rename/
//             dispatch and the MUL pipeline. It holds up to DEPTH renamed ops
//             in a collapsing queue (entry 0 is the oldest) and snoops the CDB
//             broadcast ports for operand wakeups. Each cycle it issues at most
//             one op, the oldest ready one, through registered issue outputs.
//  Ports    : clk, rst (async, active-low)
//             flush        - clear all entries and issue regs at the next edge
//             freeze_back  - hold issue regs, suppress select/removal
//             disp_*       - dispatch request, source tags/ready, dst, ROB tag
//             full         - queue holds DEPTH entries
//             wb_valid/tag - NCDB wakeup broadcast ports
//             iss_*        - registered issue port to the PRF and MUL unit
//  Revision : 1.0  initial release
// ============================================================================
module mul_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PRF_W = 5,
    parameter int ROB_W = 4,
    parameter int NCDB  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze_back,
    input  logic                  disp_valid,
    input  logic [PRF_W-1:0]      disp_src_a,
    input  logic                  disp_rdy_a,
    input  logic [PRF_W-1:0]      disp_src_b,
    input  logic                  disp_rdy_b,
    input  logic [PRF_W-1:0]      disp_dst,
    input  logic [ROB_W-1:0]      disp_rob,
    output logic                  full,
    input  logic [NCDB-1:0]       wb_valid,
    input  logic [NCDB*PRF_W-1:0] wb_tag,
    output logic                  iss_valid,
    output logic [PRF_W-1:0]      iss_src_a,
    output logic [PRF_W-1:0]      iss_src_b,
    output logic [PRF_W-1:0]      iss_prf_dst,
    output logic [ROB_W-1:0]      iss_rob_tag
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    // Queue storage
    logic               r_v     [DEPTH];
    logic [PRF_W-1:0]   r_src_a [DEPTH];
    logic               r_rdy_a [DEPTH];
    logic [PRF_W-1:0]   r_src_b [DEPTH];
    logic               r_rdy_b [DEPTH];
    logic [PRF_W-1:0]   r_dst   [DEPTH];
    logic [ROB_W-1:0]   r_rob   [DEPTH];
    logic [c_CNT_W-1:0] r_count;

    // Next-state image of the queue after shift, wakeup and dispatch
    logic               w_v     [DEPTH];
    logic [PRF_W-1:0]   w_src_a [DEPTH];
    logic               w_rdy_a [DEPTH];
    logic [PRF_W-1:0]   w_src_b [DEPTH];
    logic               w_rdy_b [DEPTH];
    logic [PRF_W-1:0]   w_dst   [DEPTH];
    logic [ROB_W-1:0]   w_rob   [DEPTH];
    logic [c_CNT_W-1:0] w_count;

    // Issue registers
    logic               r_iss_valid;
    logic [PRF_W-1:0]   r_iss_src_a;
    logic [PRF_W-1:0]   r_iss_src_b;
    logic [PRF_W-1:0]   r_iss_dst;
    logic [ROB_W-1:0]   r_iss_rob;

    logic               w_sel_found;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_issue;
    logic               w_disp;
    logic [c_CNT_W-1:0] w_wr_idx;
    int                 w_src;

    // Any valid broadcast port carrying this tag
    function automatic logic f_match(input logic [PRF_W-1:0]      tag,
                                     input logic [NCDB-1:0]       vld,
                                     input logic [NCDB*PRF_W-1:0] tags);
        logic m;
        m = 1'b0;
        for (int p = 0; p < NCDB; p++) begin
            if (vld[p] && (tags[p*PRF_W +: PRF_W] == tag)) begin
                m = 1'b1;
            end
        end
        return m;
    endfunction

    assign full = (r_count == c_FULL);

    // Oldest ready entry, judged on the registered ready bits only, so a
    // wakeup seen this cycle can be selected no earlier than next cycle.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_v[i] && r_rdy_a[i] && r_rdy_b[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_issue  = w_sel_found && !freeze_back && !flush;
    // Fullness is judged before this cycle's issue: a slot freed by an issue
    // in the same cycle is not offered to dispatch.
    assign w_disp   = disp_valid && !full && !flush;
    // After a same-cycle issue the tail has moved down by one.
    assign w_wr_idx = w_issue ? (r_count - c_ONE) : r_count;

    always_comb begin
        w_src = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w_v[i]     = 1'b0;
            w_src_a[i] = '0;
            w_rdy_a[i] = 1'b0;
            w_src_b[i] = '0;
            w_rdy_b[i] = 1'b0;
            w_dst[i]   = '0;
            w_rob[i]   = '0;

            // Entries above the issued one collapse down by one slot.
            w_src = (w_issue && (i >= int'(w_sel_idx))) ? i + 1 : i;
            if (w_src < DEPTH) begin
                w_v[i]     = r_v[w_src];
                w_src_a[i] = r_src_a[w_src];
                w_rdy_a[i] = r_rdy_a[w_src] | f_match(r_src_a[w_src], wb_valid, wb_tag);
                w_src_b[i] = r_src_b[w_src];
                w_rdy_b[i] = r_rdy_b[w_src] | f_match(r_src_b[w_src], wb_valid, wb_tag);
                w_dst[i]   = r_dst[w_src];
                w_rob[i]   = r_rob[w_src];
            end

            // A dispatching op also catches a wakeup broadcast in its own cycle.
            if (w_disp && (w_wr_idx == c_CNT_W'(i))) begin
                w_v[i]     = 1'b1;
                w_src_a[i] = disp_src_a;
                w_rdy_a[i] = disp_rdy_a | f_match(disp_src_a, wb_valid, wb_tag);
                w_src_b[i] = disp_src_b;
                w_rdy_b[i] = disp_rdy_b | f_match(disp_src_b, wb_valid, wb_tag);
                w_dst[i]   = disp_dst;
                w_rob[i]   = disp_rob;
            end
        end
    end

    always_comb begin
        w_count = r_count;
        if (w_disp && !w_issue) begin
            w_count = r_count + c_ONE;
        end else if (w_issue && !w_disp) begin
            w_count = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i]     <= 1'b0;
                r_src_a[i] <= '0;
                r_rdy_a[i] <= 1'b0;
                r_src_b[i] <= '0;
                r_rdy_b[i] <= 1'b0;
                r_dst[i]   <= '0;
                r_rob[i]   <= '0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_src_a <= '0;
            r_iss_src_b <= '0;
            r_iss_dst   <= '0;
            r_iss_rob   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i] <= 1'b0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_src_a <= '0;
            r_iss_src_b <= '0;
            r_iss_dst   <= '0;
            r_iss_rob   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i]     <= w_v[i];
                r_src_a[i] <= w_src_a[i];
                r_rdy_a[i] <= w_rdy_a[i];
                r_src_b[i] <= w_src_b[i];
                r_rdy_b[i] <= w_rdy_b[i];
                r_dst[i]   <= w_dst[i];
                r_rob[i]   <= w_rob[i];
            end
            r_count <= w_count;
            if (!freeze_back) begin
                r_iss_valid <= w_sel_found;
                // Payload holds when nothing is selected; only valid drops.
                if (w_sel_found) begin
                    r_iss_src_a <= r_src_a[w_sel_idx];
                    r_iss_src_b <= r_src_b[w_sel_idx];
                    r_iss_dst   <= r_dst[w_sel_idx];
                    r_iss_rob   <= r_rob[w_sel_idx];
                end
            end
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_src_a   = r_iss_src_a;
    assign iss_src_b   = r_iss_src_b;
    assign iss_prf_dst = r_iss_dst;
    assign iss_rob_tag = r_iss_rob;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_issue_queue
//  Purpose  : Self-checking bench for mul_issue_queue. A table of per-cycle
//             vectors drives dispatch/wakeup/freeze/flush and gives expected
//             iss_valid, full and held issue payload; expected issues are
//             queued when driven and popped by a monitor on each fresh issue.
//             A hand-written sequence covers asynchronous reset mid-operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_issue_queue;

    localparam int DEPTH = 4;
    localparam int PRF_W = 5;
    localparam int ROB_W = 4;
    localparam int NCDB  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             freeze_back = 1'b0;
    logic             disp_valid = 1'b0;
    logic [PRF_W-1:0] disp_src_a = '0;
    logic             disp_rdy_a = 1'b0;
    logic [PRF_W-1:0] disp_src_b = '0;
    logic             disp_rdy_b = 1'b0;
    logic [PRF_W-1:0] disp_dst = '0;
    logic [ROB_W-1:0] disp_rob = '0;
    logic             full;
    logic [NCDB-1:0]  wb_valid = '0;
    logic [NCDB*PRF_W-1:0] wb_tag = '0;
    logic             iss_valid;
    logic [PRF_W-1:0] iss_src_a;
    logic [PRF_W-1:0] iss_src_b;
    logic [PRF_W-1:0] iss_prf_dst;
    logic [ROB_W-1:0] iss_rob_tag;

    always #5 clk = ~clk;

    mul_issue_queue #(.DEPTH(DEPTH), .PRF_W(PRF_W), .ROB_W(ROB_W), .NCDB(NCDB)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
        .disp_valid(disp_valid), .disp_src_a(disp_src_a), .disp_rdy_a(disp_rdy_a),
        .disp_src_b(disp_src_b), .disp_rdy_b(disp_rdy_b), .disp_dst(disp_dst),
        .disp_rob(disp_rob), .full(full), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
        .iss_prf_dst(iss_prf_dst), .iss_rob_tag(iss_rob_tag)
    );

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] d;
        logic [3:0] r;
    } iss_t;

    typedef struct {
        logic       dv;
        logic [4:0] sa;
        logic       ra;
        logic [4:0] sb;
        logic       rb;
        logic [4:0] d;
        logic [3:0] r;
        logic [1:0] wv;
        logic [4:0] t0;
        logic [4:0] t1;
        logic       fz;
        logic       fl;
        logic       e_iv;
        logic       e_full;
        logic       e_new;
        iss_t       e;
    } vec_t;

    iss_t sbq[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    localparam iss_t NO = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic iss_t I(input logic [4:0] sa, input logic [4:0] sb,
                               input logic [4:0] d, input logic [3:0] r);
        iss_t x;
        x.sa = sa; x.sb = sb; x.d = d; x.r = r;
        return x;
    endfunction

    function automatic vec_t V(input logic dv, input logic [4:0] sa, input logic ra,
                               input logic [4:0] sb, input logic rb, input logic [4:0] d,
                               input logic [3:0] r, input logic [1:0] wv, input logic [4:0] t0,
                               input logic [4:0] t1, input logic fz, input logic fl,
                               input logic e_iv, input logic e_full, input logic e_new,
                               input iss_t e);
        vec_t v;
        v.dv = dv; v.sa = sa; v.ra = ra; v.sb = sb; v.rb = rb; v.d = d; v.r = r;
        v.wv = wv; v.t0 = t0; v.t1 = t1; v.fz = fz; v.fl = fl;
        v.e_iv = e_iv; v.e_full = e_full; v.e_new = e_new; v.e = e;
        return v;
    endfunction

    function automatic vec_t IDL(input logic ef);
        return V(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, ef, 0, NO);
    endfunction

    function automatic vec_t ISS(input logic ef, input iss_t e);
        return V(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, ef, 1, e);
    endfunction

    // Drive at the falling edge, check 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        disp_valid  = v.dv;
        disp_src_a  = v.sa;
        disp_rdy_a  = v.ra;
        disp_src_b  = v.sb;
        disp_rdy_b  = v.rb;
        disp_dst    = v.d;
        disp_rob    = v.r;
        wb_valid    = v.wv;
        wb_tag      = {v.t1, v.t0};
        freeze_back = v.fz;
        flush       = v.fl;
        if (v.e_new) sbq.push_back(v.e);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d iss_valid", idx), 32'(iss_valid), 32'(v.e_iv));
        chk($sformatf("v%0d full", idx), 32'(full), 32'(v.e_full));
        if (v.e_iv) begin
            chk($sformatf("v%0d iss_payload", idx),
                32'({iss_src_a, iss_src_b, iss_prf_dst, iss_rob_tag}), 32'(v.e));
        end
    endtask

    // Scoreboard: every fresh issue (edge without freeze/flush/reset) pops one.
    always @(posedge clk) begin
        logic fz, fl, rs;
        iss_t exp;
        fz = freeze_back;
        fl = flush;
        rs = rst;
        #1;
        if (rs && !fz && !fl && iss_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_issue", 32'({iss_src_a, iss_src_b, iss_prf_dst, iss_rob_tag}), 32'h7ffff);
            end else begin
                exp = sbq.pop_front();
                chk("issue_order", 32'({iss_src_a, iss_src_b, iss_prf_dst, iss_rob_tag}), 32'(exp));
            end
        end
    end

    initial begin
        // Ready op issues one cycle after dispatch; queue then empty.
        vecs.push_back(V(1, 1, 1, 2, 1, 7, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(ISS(0, I(1, 2, 7, 3)));
        vecs.push_back(IDL(0));
        // Wakeup on port 0 two cycles later; issue one cycle after wakeup.
        vecs.push_back(V(1, 9, 0, 2, 1, 8, 4, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(IDL(0));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(ISS(0, I(9, 2, 8, 4)));
        vecs.push_back(IDL(0));
        // Wakeup on port 1 in the dispatch cycle.
        vecs.push_back(V(1, 3, 1, 12, 0, 10, 5, 2'b10, 0, 12, 0, 0, 0, 0, 0, NO));
        vecs.push_back(ISS(0, I(3, 12, 10, 5)));
        vecs.push_back(IDL(0));
        // Fill with non-ready ops, drop 5th, wake entry 2, then drain.
        vecs.push_back(V(1, 20, 0, 1, 1, 16, 6, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 21, 0, 1, 1, 17, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 22, 0, 1, 1, 18, 8, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 23, 0, 1, 1, 19, 9, 2'b00, 0, 0, 0, 0, 0, 1, 0, NO));
        vecs.push_back(V(1, 0, 1, 0, 1, 20, 10, 2'b00, 0, 0, 0, 0, 0, 1, 0, NO));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b01, 22, 0, 0, 0, 0, 1, 0, NO));
        vecs.push_back(ISS(0, I(22, 1, 18, 8)));
        vecs.push_back(IDL(0));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b11, 23, 20, 0, 0, 0, 0, 0, NO));
        vecs.push_back(ISS(0, I(20, 1, 16, 6)));
        vecs.push_back(ISS(0, I(23, 1, 19, 9)));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b01, 21, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(ISS(0, I(21, 1, 17, 7)));
        vecs.push_back(IDL(0));
        // Two ready ops with a 3-cycle back-end freeze after the first issues.
        vecs.push_back(V(1, 2, 1, 3, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 4, 1, 5, 1, 2, 2, 2'b00, 0, 0, 0, 0, 1, 0, 1, I(2, 3, 1, 1)));
        for (int k = 0; k < 3; k++)
            vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, I(2, 3, 1, 1)));
        vecs.push_back(ISS(0, I(4, 5, 2, 2)));
        vecs.push_back(IDL(0));
        // Flush of 3 entries with a colliding dispatch; later wakeups find nothing.
        vecs.push_back(V(1, 24, 0, 1, 1, 21, 11, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 25, 0, 1, 1, 22, 12, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 26, 0, 1, 1, 23, 13, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 0, 1, 0, 1, 22, 14, 2'b00, 0, 0, 0, 1, 0, 0, 0, NO));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b11, 24, 25, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b01, 26, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(IDL(0));
        vecs.push_back(IDL(0));
        // Count restarted at 0: full only after four more dispatches.
        vecs.push_back(V(1, 30, 0, 1, 1, 24, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 30, 0, 1, 1, 25, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 30, 0, 1, 1, 26, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0, NO));
        vecs.push_back(V(1, 30, 0, 1, 1, 27, 3, 2'b00, 0, 0, 0, 0, 0, 1, 0, NO));
        vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 2'b01, 30, 0, 0, 0, 0, 1, 0, NO));
        // Dispatch while full is rejected even though this edge issues.
        vecs.push_back(V(1, 0, 1, 0, 1, 28, 15, 2'b00, 0, 0, 0, 0, 1, 0, 1, I(30, 1, 24, 0)));
        vecs.push_back(ISS(0, I(30, 1, 25, 1)));
        vecs.push_back(ISS(0, I(30, 1, 26, 2)));
        vecs.push_back(ISS(0, I(30, 1, 27, 3)));
        vecs.push_back(IDL(0));
        vecs.push_back(IDL(0));

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset iss_valid", 32'(iss_valid), 32'd0);
        chk("reset full", 32'(full), 32'd0);
        chk("reset iss_payload", 32'({iss_src_a, iss_src_b, iss_prf_dst, iss_rob_tag}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset while an op is on the issue port and 3 remain queued.
        for (int k = 0; k < 4; k++)
            apply(V(1, 31, 0, 2, 1, 5'(k + 1), 4'(k + 1), 2'b00, 0, 0, 0, 0, 0, (k == 3), 0, NO), 100 + k);
        apply(V(0, 0, 0, 0, 0, 0, 0, 2'b01, 31, 0, 0, 0, 0, 1, 0, NO), 104);
        apply(ISS(0, I(31, 2, 1, 1)), 105);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst iss_valid", 32'(iss_valid), 32'd0);
        chk("async_rst full", 32'(full), 32'd0);
        chk("async_rst iss_payload", 32'({iss_src_a, iss_src_b, iss_prf_dst, iss_rob_tag}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) apply(IDL(0), 106 + k);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
